// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- program counter and fetch-redirect stage.
//
// Drives the fetch address to instruction memory and the branch predictor,
// follows the predictor's next-PC, and keeps an in-order queue of in-flight
// predictions. When EX resolves an instruction, the resolved next PC is checked
// against the oldest queued prediction. On a mismatch, fetch is redirected, the
// queue is flushed and a one-cycle invalidate pulse is raised.
//
// Parameters : PC_INIT (reset PC), QDEPTH (queue entries, power of two, >= 2)
// Inputs     : CLK, RST (sync, active high), ihit, stall, halt, bp_pc[31:0],
//              ex_valid, ex_next_pc[31:0]
// Outputs    : curr_pc[31:0], imemREN, update_pc[31:0], update_en, invalidate,
//              q_full, q_underflow, branch_cnt[31:0], mispredict_cnt[31:0]
// Build option: define PC_FETCH_STATS_EN to build the resolution/mispredict
//              counters. Without it, both counter outputs are tied to zero.
module pc_fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000,
   parameter int          QDEPTH  = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        stall,
   input  logic        halt,
   input  logic [31:0] bp_pc,
   input  logic        ex_valid,
   input  logic [31:0] ex_next_pc,
   output logic [31:0] curr_pc,
   output logic        imemREN,
   output logic [31:0] update_pc,
   output logic        update_en,
   output logic        invalidate,
   output logic        q_full,
   output logic        q_underflow,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispredict_cnt
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_REDIR = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          halt_q;
   logic [31:0]   pc_q, pc_d;
   // Only the predicted target is compared at resolve time, so that is all
   // each entry keeps.
   logic [31:0]   pred_q [QDEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   upd_pc_q;
   logic          upd_en_q;
   logic          unf_q;

   logic q_empty, pop, push, mispredict, halt_seen;

   assign q_empty    = (cnt_q == '0);
   assign q_full     = (cnt_q == CW'(QDEPTH));
   assign pop        = ex_valid & ~q_empty;
   assign mispredict = pop & (pred_q[head_q] != ex_next_pc);
   // Full is acceptable when the head leaves in the same cycle.
   assign push       = (state_q == S_RUN) & ihit & ~stall & (~q_full | pop) & ~mispredict;
   assign halt_seen  = halt | halt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (mispredict)     state_d = S_REDIR;
                  else if (halt_seen) state_d = S_HALT;
         S_REDIR: state_d = halt_seen ? S_HALT : S_RUN;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RUN;
      endcase
   end

   // A halted fetch never moves, even when a late mispredict is detected.
   always_comb begin
      pc_d = pc_q;
      if (mispredict && state_q != S_HALT) pc_d = ex_next_pc;
      else if (push)                       pc_d = bp_pc;
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_RUN;
         halt_q   <= 1'b0;
         pc_q     <= PC_INIT;
         head_q   <= '0;
         tail_q   <= '0;
         cnt_q    <= '0;
         upd_pc_q <= '0;
         upd_en_q <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         upd_en_q <= pop;
         if (halt)                 halt_q   <= 1'b1;
         if (pop)                  upd_pc_q <= ex_next_pc;
         if (ex_valid && q_empty)  unf_q    <= 1'b1;
         if (mispredict) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_d;
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
         end
      end
   end

   // Entry storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge CLK) begin
      if (push) pred_q[tail_q] <= bp_pc;
   end

`ifdef PC_FETCH_STATS_EN
   logic [31:0] br_cnt_q, mp_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
      end else begin
         if (pop)        br_cnt_q <= br_cnt_q + 32'd1;
         if (mispredict) mp_cnt_q <= mp_cnt_q + 32'd1;
      end
   end

   assign branch_cnt     = br_cnt_q;
   assign mispredict_cnt = mp_cnt_q;
`else
   assign branch_cnt     = 32'd0;
   assign mispredict_cnt = 32'd0;
`endif

   assign curr_pc     = pc_q;
   assign imemREN     = (state_q == S_RUN);
   assign invalidate  = (state_q == S_REDIR);
   assign update_pc   = upd_pc_q;
   assign update_en   = upd_en_q;
   assign q_underflow = unf_q;

endmodule
